// File: rtl/sonata_pkg.sv
// Shared constants for the board-input path: default debounce time, gp_i field
// layout and the conditioner control-state encoding.
package sonata_pkg;

    // 5 ms at a 40 MHz system clock
    localparam int DebounceCyclesDefault = 200_000;

    localparam int GpSwitchLsb    = 0;
    localparam int GpSwitchWidth  = 8;
    localparam int GpJoystickLsb  = 8;
    localparam int GpJoystickWidth = 5;
    localparam int GpSelectBit    = 13;
    localparam int GpCardDetBit   = 14;

    // Wide enough to count up to the deepest synchroniser (4 stages)
    localparam int InitCntWidth = 3;

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } cond_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One board input: metastability synchroniser, polarity correction, stable-cycle
// counter and the accepted level with its registered rise/fall pulses.
module debounce_channel #(
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = 8,
    parameter bit ActiveLow      = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    input  logic load_i,
    input  logic run_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CntWidth   = (DebounceCycles < 1) ? 1 : $clog2(DebounceCycles + 1);
    localparam int CntLastInt = (DebounceCycles > 0) ? DebounceCycles - 1 : 0;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(CntLastInt);

    logic [SyncStages-1:0] sync_q, sync_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  level_q, level_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  sync_lvl;
    logic                  mismatch;

    always_comb begin
        sync_d = {sync_q[SyncStages-2:0], pin_i};
    end

    assign sync_lvl = sync_q[SyncStages-1] ^ ActiveLow;
    assign mismatch = (sync_lvl != level_q);

    // Any sample equal to the current level restarts the count, so bounce never accumulates
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (load_i) begin
            level_d = sync_lvl;
            cnt_d   = '0;
        end else if (run_i) begin
            if (!mismatch) begin
                cnt_d = '0;
            end else if ((DebounceCycles == 0) || (cnt_q == CntLast)) begin
                level_d = sync_lvl;
                rise_d  = sync_lvl;
                fall_d  = ~sync_lvl;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/board_input_conditioner.sv
// Conditions raw board pads into debounced levels, edge pulses and sticky,
// individually enabled edge events with a combined interrupt.
module board_input_conditioner
    import sonata_pkg::*;
#(
    parameter int               Width          = 16,
    parameter int               SyncStages     = 2,
    parameter int               DebounceCycles = DebounceCyclesDefault,
    parameter logic [Width-1:0] ActiveLowMask  = '1
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_i,
    input  logic [Width-1:0] pins_i,
    input  logic [Width-1:0] rise_en_i,
    input  logic [Width-1:0] fall_en_i,
    input  logic [Width-1:0] event_clr_i,
    output logic [Width-1:0] level_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o,
    output logic [Width-1:0] event_o,
    output logic             irq_o,
    output logic             ready_o
);

    cond_state_e             state_q, state_d;
    logic [InitCntWidth-1:0] init_cnt_q, init_cnt_d;
    logic [Width-1:0]        event_q, event_d;
    logic                    load;
    logic                    run;

    // INIT waits for the synchronisers to fill, then takes the pins as-is without edges
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        load       = 1'b0;
        run        = 1'b0;
        case (state_q)
            StInit: begin
                if (init_cnt_q == InitCntWidth'(SyncStages)) begin
                    load    = 1'b1;
                    state_d = StRun;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            StRun: begin
                run = 1'b1;
            end
        endcase
    end

    for (genvar i = 0; i < Width; i++) begin : g_chan
        debounce_channel #(
            .SyncStages    (SyncStages),
            .DebounceCycles(DebounceCycles),
            .ActiveLow     (ActiveLowMask[i])
        ) u_chan (
            .clk_i  (clk_sys_i),
            .rst_i  (rst_sys_i),
            .pin_i  (pins_i[i]),
            .load_i (load),
            .run_i  (run),
            .level_o(level_o[i]),
            .rise_o (rise_o[i]),
            .fall_o (fall_o[i])
        );
    end

    // A new edge wins over a clear arriving in the same cycle
    always_comb begin
        event_d = (event_q & ~event_clr_i)
                | (rise_o & rise_en_i)
                | (fall_o & fall_en_i);
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            event_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            event_q    <= event_d;
        end
    end

    assign event_o = event_q;
    assign irq_o   = |event_q;
    assign ready_o = (state_q == StRun);

endmodule

// File: tb/tb_board_input_conditioner.sv
// Directed bench: a cycle-step vector table for start-up, debounce, bounce
// rejection and event clearing, plus hand sequences for mid-debounce reset and bypass.
module tb_board_input_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] pins    = 4'b1110;
    logic [3:0] ren     = 4'b0000;
    logic [3:0] fen     = 4'b0000;
    logic [3:0] clr     = 4'b0000;
    logic [3:0] level, rise, fall, evt;
    logic       irq, rdy;

    logic [3:0] pins0 = 4'b1111;
    logic [3:0] ren0  = 4'b0000;
    logic [3:0] fen0  = 4'b0000;
    logic [3:0] clr0  = 4'b0000;
    logic [3:0] level0, rise0, fall0, evt0;
    logic       irq0, rdy0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] pins;
        logic [3:0] ren;
        logic [3:0] fen;
        logic [3:0] clr;
        int         ncyc;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] evt;
        logic       irq;
        logic       rdy;
    } vec_t;

    vec_t tbl[$];

    board_input_conditioner #(
        .Width(4), .SyncStages(2), .DebounceCycles(8), .ActiveLowMask(4'b1111)
    ) dut (
        .clk_sys_i(clk), .rst_sys_i(rst), .pins_i(pins),
        .rise_en_i(ren), .fall_en_i(fen), .event_clr_i(clr),
        .level_o(level), .rise_o(rise), .fall_o(fall), .event_o(evt),
        .irq_o(irq), .ready_o(rdy)
    );

    board_input_conditioner #(
        .Width(4), .SyncStages(2), .DebounceCycles(0), .ActiveLowMask(4'b1111)
    ) dut0 (
        .clk_sys_i(clk), .rst_sys_i(rst), .pins_i(pins0),
        .rise_en_i(ren0), .fall_en_i(fen0), .event_clr_i(clr0),
        .level_o(level0), .rise_o(rise0), .fall_o(fall0), .event_o(evt0),
        .irq_o(irq0), .ready_o(rdy0)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] l, input logic [3:0] r,
                           input logic [3:0] f, input logic [3:0] e, input logic i,
                           input logic y);
        chk({tag, ".level"}, {28'd0, level}, {28'd0, l});
        chk({tag, ".rise"},  {28'd0, rise},  {28'd0, r});
        chk({tag, ".fall"},  {28'd0, fall},  {28'd0, f});
        chk({tag, ".event"}, {28'd0, evt},   {28'd0, e});
        chk({tag, ".irq"},   {31'd0, irq},   {31'd0, i});
        chk({tag, ".ready"}, {31'd0, rdy},   {31'd0, y});
    endtask

    function automatic vec_t mk(input logic [3:0] p, input logic [3:0] re, input logic [3:0] fe,
                                input logic [3:0] c, input int n, input logic [3:0] l,
                                input logic [3:0] r, input logic [3:0] f, input logic [3:0] e,
                                input logic i, input logic y);
        vec_t v;
        v.pins = p; v.ren = re; v.fen = fe; v.clr = c; v.ncyc = n;
        v.lvl = l; v.rise = r; v.fall = f; v.evt = e; v.irq = i; v.rdy = y;
        return v;
    endfunction

    initial begin
        // start-up after reset: level loads on the third edge with no activity
        tbl.push_back(mk(4'b1110, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(4'b1110, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(4'b1110, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 1));
        tbl.push_back(mk(4'b1110, 4'b0000, 4'b0000, 4'b0000, 3, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 1));
        // channel 1 pressed: accepted 10 cycles later, event one cycle after
        tbl.push_back(mk(4'b1100, 4'b0010, 4'b0000, 4'b0000, 9, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 1));
        tbl.push_back(mk(4'b1100, 4'b0010, 4'b0000, 4'b0000, 1, 4'b0011, 4'b0010, 4'b0000, 4'b0000, 0, 1));
        tbl.push_back(mk(4'b1100, 4'b0010, 4'b0000, 4'b0000, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 1, 1));
        tbl.push_back(mk(4'b1100, 4'b0010, 4'b0000, 4'b0000, 3, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 1, 1));
        // channel 2 bounces for 7 cycles, three times: never accepted
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mk(4'b1000, 4'b0010, 4'b0000, 4'b0000, 7, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 1, 1));
            tbl.push_back(mk(4'b1100, 4'b0010, 4'b0000, 4'b0000, 3, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 1, 1));
        end
        tbl.push_back(mk(4'b1100, 4'b0010, 4'b0000, 4'b0000, 8, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 1, 1));
        // channel 1 released with fall enabled; clear coincides with the new edge
        tbl.push_back(mk(4'b1110, 4'b0000, 4'b0010, 4'b0000, 9, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 1, 1));
        tbl.push_back(mk(4'b1110, 4'b0000, 4'b0010, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 1, 1));
        tbl.push_back(mk(4'b1110, 4'b0000, 4'b0010, 4'b0010, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 1, 1));
        tbl.push_back(mk(4'b1110, 4'b0000, 4'b0010, 4'b0000, 2, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 1, 1));
        tbl.push_back(mk(4'b1110, 4'b0000, 4'b0010, 4'b0010, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 1));
        tbl.push_back(mk(4'b1110, 4'b0000, 4'b0010, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 1));

        // reset state
        tick(2);
        chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("reset.level0", {28'd0, level0}, 32'd0);
        chk("reset.ready0", {31'd0, rdy0}, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < tbl.size(); v++) begin
            pins = tbl[v].pins;
            ren  = tbl[v].ren;
            fen  = tbl[v].fen;
            clr  = tbl[v].clr;
            tick(tbl[v].ncyc);
            chk_all($sformatf("vec%0d", v), tbl[v].lvl, tbl[v].rise, tbl[v].fall,
                    tbl[v].evt, tbl[v].irq, tbl[v].rdy);
        end
        clr = 4'b0000;

        // reset in the middle of a channel-3 debounce
        pins = 4'b0110;
        ren  = 4'b1111;
        fen  = 4'b1111;
        tick(5);
        chk("midrst.pre_level", {28'd0, level}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk_all("midrst.async", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("midrst.rel0.ready", {31'd0, rdy}, 32'd0);
        tick(1);
        chk("midrst.rel1.ready", {31'd0, rdy}, 32'd0);
        chk("midrst.rel1.level", {28'd0, level}, 32'd0);
        tick(1);
        chk_all("midrst.reload", 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        tick(12);
        chk_all("midrst.quiet", 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);

        // debounce bypass build: level follows the pin three edges later
        chk("byp.ready", {31'd0, rdy0}, 32'd1);
        chk("byp.idle_level", {28'd0, level0}, 32'd0);
        pins0 = 4'b1110;
        tick(2);
        chk("byp.rise_early", {28'd0, level0}, 32'd0);
        tick(1);
        chk("byp.rise_level", {28'd0, level0}, 32'h1);
        chk("byp.rise_pulse", {28'd0, rise0}, 32'h1);
        tick(1);
        chk("byp.rise_end", {28'd0, rise0}, 32'd0);
        pins0 = 4'b1111;
        tick(2);
        chk("byp.fall_early", {28'd0, level0}, 32'h1);
        tick(1);
        chk("byp.fall_level", {28'd0, level0}, 32'd0);
        chk("byp.fall_pulse", {28'd0, fall0}, 32'h1);
        tick(1);
        chk("byp.fall_end", {28'd0, fall0}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
